// File: rtl/arb_pkg.sv
// Shared types and lane-select helpers for the memory port arbiter.
// Build option ALIGN_CHECK_EN is consumed by mem_port_arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    SZ_W = 2'd0,
    SZ_H = 2'd1,
    SZ_B = 2'd2
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR,
    RMW_WAIT,
    RMW_WR
  } arb_state_t;

  function automatic logic [1:0] lane_off(
    input size_t      sz,
    input logic [1:0] a
  );
    logic [1:0] off;
    off = 2'b00;
    unique case (sz)
      SZ_B:    off = a;
      SZ_H:    off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic [3:0] lane_mask(
    input size_t      sz,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'hf;
    unique case (sz)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'hf;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_bits(
    input logic [3:0] m
  );
    logic [31:0] b;
    for (int k = 0; k < 4; k++) begin
      b[8*k +: 8] = {8{m[k]}};
    end
    return b;
  endfunction

  function automatic logic [31:0] lane_rep(
    input size_t       sz,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    unique case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane extract (zero-extend) for loads and
// lane merge of right-justified store data into an old word.
module byte_lane_merge
  import arb_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  size_t       sz;
  logic [31:0] sh;
  logic [31:0] bm;
  logic [31:0] rep;

  assign sz  = size_t'(size);
  assign sh  = rd_word >> {off, 3'b000};
  assign bm  = lane_bits(lane_mask(sz, off));
  assign rep = lane_rep(sz, wdata);

  always_comb begin
    ext = rd_word;
    unique case (sz)
      SZ_B:    ext = {24'h0, sh[7:0]};
      SZ_H:    ext = {16'h0, sh[15:0]};
      default: ext = rd_word;
    endcase
  end

  assign merged = (old_word & ~bm) | (rep & bm);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and load/store traffic.
// Define ALIGN_CHECK_EN to flag misaligned data accesses on err_d.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        gnt_i,
  output logic        done_i,
  input  logic        req_d,
  input  logic        we_d,
  input  logic [1:0]  size_d,
  input  logic [31:0] addr_d,
  input  logic [31:0] wdata_d,
  output logic        gnt_d,
  output logic        done_d,
  output logic        err_d,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW =
    (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_INIT =
    CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP =
    SW'(STARVE_MAX);

  arb_state_t    state;
  arb_state_t    nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;

  logic        cap_f;
  logic        cap_err;
  size_t       cap_sz;
  logic [1:0]  cap_off;
  logic [29:0] cap_wa;
  logic [31:0] cap_wd;
  logic [31:0] old_q;
  logic [31:0] rdata_q;

  logic        idle;
  logic        pick_i;
  logic        pick_d;
  logic        mis;
  logic        sub_st;
  logic        wait_last;
  size_t       sz_in;
  logic [1:0]  off_in;
  logic [31:0] ext;
  logic [31:0] merged;
  logic        unused_bits;

  assign unused_bits = ^addr_i[1:0];

  assign sz_in  = size_t'(size_d);
  assign off_in = lane_off(sz_in, addr_d[1:0]);
  assign sub_st = (sz_in == SZ_H) || (sz_in == SZ_B);

`ifdef ALIGN_CHECK_EN
  assign mis = (sz_in == SZ_H) ? addr_d[0] :
               (sz_in == SZ_B) ? 1'b0 :
               (addr_d[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign idle = (state == IDLE);

  // Data wins a conflict until fetch has lost STARVE_MAX times.
  assign pick_i = idle && reset && req_i &&
                  (!req_d || (starve == STARVE_TOP));
  assign pick_d = idle && reset && req_d && !pick_i;

  assign wait_last = (cnt == '0);

  byte_lane_merge u_lane (
    .rd_word  (mem_rdata),
    .old_word (old_q),
    .wdata    (cap_wd),
    .size     (cap_sz),
    .off      (cap_off),
    .ext      (ext),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt       = state;
    gnt_i     = pick_i;
    gnt_d     = pick_d;
    done_i    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    mem_addr  = {cap_wa, 2'b00};
    unique case (state)
      IDLE: begin
        mem_addr = '0;
        if (pick_i) begin
          nxt = RD_WAIT;
        end else if (pick_d) begin
          if (mis) begin
            nxt = WR;
          end else if (!we_d) begin
            nxt = RD_WAIT;
          end else if (sub_st) begin
            nxt = RMW_WAIT;
          end else begin
            nxt = WR;
          end
        end
      end
      RD_WAIT: begin
        if (wait_last) nxt = RD_DONE;
      end
      RD_DONE: begin
        done_i = cap_f;
        done_d = !cap_f;
        nxt    = IDLE;
      end
      WR: begin
        done_d    = 1'b1;
        err_d     = cap_err;
        mem_wr    = !cap_err;
        mem_wdata = cap_err ? '0 : cap_wd;
        nxt       = IDLE;
      end
      RMW_WAIT: begin
        if (wait_last) nxt = RMW_WR;
      end
      RMW_WR: begin
        done_d    = 1'b1;
        mem_wr    = 1'b1;
        mem_wdata = merged;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      cap_f   <= 1'b0;
      cap_err <= 1'b0;
      cap_sz  <= SZ_W;
      cap_off <= 2'b00;
      cap_wa  <= '0;
      cap_wd  <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else if (pick_i || pick_d) begin
      cnt     <= CNT_INIT;
      cap_f   <= pick_i;
      cap_err <= pick_d && mis;
      cap_sz  <= pick_i ? SZ_W : sz_in;
      cap_off <= pick_i ? 2'b00 : off_in;
      cap_wa  <= pick_i ? addr_i[31:2]
                        : addr_d[31:2];
      cap_wd  <= wdata_d;
      if (pick_d && mis) rdata_q <= '0;
    end else if (state == RD_WAIT ||
                 state == RMW_WAIT) begin
      if (!wait_last) begin
        cnt <= cnt - 1'b1;
      end else if (state == RD_WAIT) begin
        rdata_q <= ext;
      end else begin
        old_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve <= '0;
    end else if (pick_i) begin
      starve <= '0;
    end else if (pick_d && req_i &&
                 starve != STARVE_TOP) begin
      starve <= starve + 1'b1;
    end
  end

  assign rdata = rdata_q;
  assign busy  = !idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Honours ALIGN_CHECK_EN when the design is built with it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        gnt_i;
  logic        done_i;
  logic        req_d = 1'b0;
  logic        we_d = 1'b0;
  logic [1:0]  size_d = 2'd0;
  logic [31:0] addr_d = '0;
  logic [31:0] wdata_d = '0;
  logic        gnt_d;
  logic        done_d;
  logic        err_d;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(
    .MEM_LAT    (2),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .gnt_i     (gnt_i),
    .done_i    (done_i),
    .req_d     (req_d),
    .we_d      (we_d),
    .size_d    (size_d),
    .addr_d    (addr_d),
    .wdata_d   (wdata_d),
    .gnt_d     (gnt_d),
    .done_d    (done_d),
    .err_d     (err_d),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          f;
    bit          cr;
    bit          err;
    logic [31:0] rd;
    int          t;
    int          lat;
  } sb_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          t;
    int          lat;
  } wr_t;

  sb_t         sbq[$];
  wr_t         wq[$];
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;
  int          n_dgnt = 0;
  int          dgnt_at_i = 0;
  int          t_gi = 0;
  int          t_gd = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  // Memory macro: one register stage on the read path.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem[mem_addr[9:2]];
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (done_i && done_d) chk("done_both", 1, 0);
      if (done_i || done_d) begin
        if (sbq.size() == 0) begin
          chk("done_spurious", 1, 0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("done_kind", {31'h0, done_i},
              {31'h0, e.f});
          chk("done_lat", cyc - e.t, e.lat);
          chk("err_d", {31'h0, err_d},
              {31'h0, e.err});
          if (e.cr) chk("rdata", rdata, e.rd);
        end
      end
      if (mem_wr) begin
        if (wq.size() == 0) begin
          chk("wr_spurious", 1, 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_wdata, w.d);
          chk("wr_lat", cyc - w.t, w.lat);
        end
      end
    end
  end

  function automatic logic [31:0] ref_load(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  off
  );
    if (sz == 2'd2) return {24'h0, w[8*off +: 8]};
    if (sz == 2'd1) return {16'h0, w[16*off[1] +: 16]};
    return w;
  endfunction

  task automatic model_data(
    input logic        we,
    input logic [1:0]  sz,
    input logic [31:0] a
  , input logic [31:0] wd
  );
    sb_t         e;
    wr_t         w;
    logic [31:0] old;
    logic [7:0]  wi;
    bit          bad;
    wi  = a[9:2];
    old = ref_mem[wi];
    bad = 1'b0;
`ifdef ALIGN_CHECK_EN
    bad = (sz == 2'd1) ? a[0] :
          (sz == 2'd0) ? (a[1:0] != 2'b00) : 1'b0;
`endif
    e.f = 1'b0; e.t = cyc; e.err = bad;
    e.cr = 1'b1; e.rd = '0; e.lat = 3;
    if (bad) begin
      e.lat = 1;
    end else if (!we) begin
      e.rd = ref_load(old, sz, a[1:0]);
    end else begin
      e.cr = 1'b0;
      if (sz == 2'd2) begin
        old[8*a[1:0] +: 8] = wd[7:0];
      end else if (sz == 2'd1) begin
        old[16*a[1] +: 16] = wd[15:0];
      end else begin
        old = wd;
        e.lat = 1;
      end
      ref_mem[wi] = old;
      w.a = {a[31:2], 2'b00};
      w.d = old; w.t = cyc; w.lat = e.lat;
      wq.push_back(w);
    end
    sbq.push_back(e);
  endtask

  task automatic fetch_op(input logic [31:0] a);
    int  n;
    sb_t e;
    n = 0;
    @(negedge clk);
    req_i = 1'b1; addr_i = a;
    #1;
    while (!gnt_i && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (!gnt_i) begin
      chk("gnt_i_timeout", 0, 1);
      req_i = 1'b0;
    end else begin
      t_gi = cyc; dgnt_at_i = n_dgnt;
      e.f = 1'b1; e.cr = 1'b1; e.err = 1'b0;
      e.rd = ref_mem[a[9:2]];
      e.t = cyc; e.lat = 3;
      sbq.push_back(e);
      @(posedge clk); #1;
      req_i = 1'b0;
    end
  endtask

  task automatic data_op(
    input logic        we,
    input logic [1:0]  sz,
    input logic [31:0] a,
    input logic [31:0] wd,
    input bit          hold
  );
    int n;
    n = 0;
    @(negedge clk);
    req_d = 1'b1; we_d = we; size_d = sz;
    addr_d = a; wdata_d = wd;
    #1;
    while (!gnt_d && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (!gnt_d) begin
      chk("gnt_d_timeout", 0, 1);
      req_d = 1'b0;
    end else begin
      t_gd = cyc; n_dgnt++;
      model_data(we, sz, a, wd);
      @(posedge clk); #1;
      if (!hold) req_d = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 0);
    chk({tag, "_memwr"}, {31'h0, mem_wr}, 0);
    chk({tag, "_done"}, {30'h0, done_i, done_d}, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
  endtask

  initial begin
    int base;
    for (int k = 0; k < 256; k++) begin
      mem[k] = (32'h0100_0193 * k) ^ 32'ha5a5_0000;
    end
    mem[4]  = 32'h1122_3344;
    mem[16] = 32'hdead_beef;
    for (int k = 0; k < 256; k++) ref_mem[k] = mem[k];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    chk("rst_gnt", {30'h0, gnt_i, gnt_d}, 0);
    reset = 1'b1;

    fetch_op(32'h40);
    @(negedge clk);
    chk("f_maddr", mem_addr, 32'h40);
    chk("f_busy", {31'h0, busy}, 1);
    @(negedge clk);
    chk("f_early", {31'h0, done_i}, 0);
    wait_idle();

    fork
      fetch_op(32'h44);
      data_op(1'b0, 2'd0, 32'h80, 0, 1'b0);
    join
    chk("arb_d_first", {31'h0, t_gd < t_gi}, 1);
    chk("arb_i_gap", t_gi - t_gd, 4);
    wait_idle();

    base = n_dgnt;
    fork
      fetch_op(32'h48);
      begin
        for (int k = 0; k < 5; k++) begin
          data_op(1'b0, 2'd0, 32'h84 + 4 * k, 0,
                  k != 4);
        end
      end
    join
    chk("starve_cnt", dgnt_at_i - base, 4);
    wait_idle();

    data_op(1'b1, 2'd2, 32'h11, 32'h0000_00aa, 1'b0);
    wait_idle();
    chk("sb_mem", mem[4], 32'h1122_aa44);
    data_op(1'b0, 2'd1, 32'h12, 0, 1'b0);
    data_op(1'b0, 2'd2, 32'h13, 0, 1'b0);
    data_op(1'b0, 2'd2, 32'h11, 0, 1'b0);
    data_op(1'b1, 2'd1, 32'h32, 32'hffff_5a6b, 1'b0);
    data_op(1'b1, 2'd0, 32'h34, 32'hcafe_f00d, 1'b0);
    data_op(1'b0, 2'd0, 32'h30, 0, 1'b0);
    data_op(1'b0, 2'd0, 32'h34, 0, 1'b0);
    data_op(1'b0, 2'd0, 32'h81, 0, 1'b0);
    data_op(1'b1, 2'd1, 32'h23, 32'h0000_1234, 1'b0);
    data_op(1'b0, 2'd0, 32'h20, 0, 1'b0);
    wait_idle();

    // Abort a sub-word store while it waits for the old word.
    @(negedge clk);
    req_d = 1'b1; we_d = 1'b1; size_d = 2'd1;
    addr_d = 32'h50; wdata_d = 32'h0000_beef;
    #1;
    chk("abort_gnt", {31'h0, gnt_d}, 1);
    @(posedge clk); #1;
    req_d = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    data_op(1'b0, 2'd0, 32'h50, 0, 1'b0);
    wait_idle();

    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      a = 32'h100 + $urandom_range(0, 63);
      if (k % 5 == 4) begin
        fetch_op({a[31:2], 2'b00});
      end else begin
        data_op(1'($urandom_range(0, 1)),
                2'($urandom_range(0, 2)),
                a, $urandom, 1'b0);
      end
    end
    wait_idle();
    chk("drain_sb", sbq.size(), 0);
    chk("drain_wq", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
